chunked_adder: RTL and testbench
================================

Name: chunked_adder

Overview:
- Multi-cycle, parametrised two's-complement adder/subtractor; successor to the team's single-cycle 32-bit combinational adder.
- Processes CHUNK bits per clock, LSB chunk first, so a wide add does not sit on one long carry chain.
- Valid/ready handshake on both sides, so it drops into datapaths that can stall.
- Adds subtract mode, carry-out and signed-overflow flags.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: bits summed per cycle. WIDTH % CHUNK must be 0 and 1 <= CHUNK <= WIDTH; elaboration fails otherwise.
- NCHUNK, derived (WIDTH/CHUNK): cycles per operation. Localparam, not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode presented.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: a+b; 1: a-b.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry_out  out  1  carry out of MSB; for sub, 1 means no borrow.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: while rst is high, in_ready=0. At the edge where rst is sampled high: state=IDLE, out_valid=0, sum=0, carry_out=0, overflow=0.
- Reset mid-operation: aborts the operation with no partial output. Result is discarded even if out_valid was high.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1 (when rst low), out_valid=0.
  - On in_valid && in_ready at an edge: latch a into op_a and (sub ? ~b : b) into op_b; carry register = sub; chunk index = 0; go to BUSY.
- BUSY: in_ready=0, out_valid=0.
  - Each edge adds chunk[idx] of op_a, op_b and carry; writes the CHUNK-bit result into sum bits [idx*CHUNK +: CHUNK]; updates carry; idx++.
  - On the final chunk, also capture carry into the MSB (for overflow) and go to DONE.
- DONE: out_valid=1. sum, carry_out and overflow are stable and unchanged until the handshake completes.
  - On out_valid && out_ready: go to IDLE.
- Latency: operation accepted at edge k gives out_valid=1 after edge k+NCHUNK. With CHUNK==WIDTH, latency is 1.
- Throughput: no overlap. in_ready rises the cycle after the output handshake, so there is no same-cycle accept-on-drain. Peak rate is one op per NCHUNK+2 cycles.
- Input stability: inputs are sampled only at the accept edge. Later changes to a, b, sub or in_valid are ignored.
- in_valid with in_ready=0 has no effect. The producer holds its data until accepted (standard valid/ready; valid must not depend on ready).
- out_ready while out_valid=0 is ignored.
- Arithmetic:
  - sum is exact modulo 2^WIDTH.
  - carry_out equals bit WIDTH of {1'b0,a} + {1'b0,(sub?~b:b)} + sub.
  - overflow is computed identically to the single-cycle reference math.
- sum holds its last value in IDLE; consumers must qualify it with out_valid.

Decomposition:
- Shared package adder_pkg holds:
  - state enum (IDLE/BUSY/DONE) and its 2-bit encoding;
  - the WIDTH/CHUNK legality check function;
  - a golden function for the {sum, carry, overflow} reference, used by the bench.
- One sub-module, chunk_add: combinational CHUNK-bit adder with cin, returning sum, cout and the carry into its own MSB.
- Top holds the FSM, index counter, operand registers, and result and flag registers.

Test Plan:
- Reset, then a=1, b=2, sub=0, WIDTH=32, CHUNK=8:
  - in_ready drops after accept;
  - out_valid is high exactly 4 cycles later;
  - sum=3, carry_out=0, overflow=0.
- a=32'hFFFF_FFFF, b=1, add:
  - sum=0, carry_out=1, overflow=0.
- a=32'h7FFF_FFFF, b=1, add:
  - sum=32'h8000_0000, carry_out=0, overflow=1.
- a=5, b=10, sub=1:
  - sum=32'hFFFF_FFFB, carry_out=0 (borrow), overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles, changing a/b/in_valid meanwhile:
  - outputs stay stable and in_ready stays 0;
  - after out_ready=1, in_ready=1 on the next cycle.
- Reset mid-BUSY at idx=2:
  - next cycle out_valid=0, sum=0, in_ready=1.
  - Repeat with CHUNK=32 (latency 1) and CHUNK=1 (latency 32) against 1000 random ops checked with the adder_pkg golden function.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked adder: FSM encoding, configuration
// legality check and a bit-serial reference model of {sum, carry, overflow}.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int GOLDEN_MAX_WIDTH = 64;

  typedef struct packed {
    logic [GOLDEN_MAX_WIDTH-1:0] sum;
    logic                        carry;
    logic                        overflow;
  } golden_t;

  function automatic bit cfg_legal(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

  // One bit at a time, so it shares no structure with the chunked datapath.
  function automatic golden_t golden(input logic [GOLDEN_MAX_WIDTH-1:0] a,
                                     input logic [GOLDEN_MAX_WIDTH-1:0] b,
                                     input logic sub, input int width);
    golden_t r;
    logic c, c_msb, bb;
    r     = '0;
    c     = sub;
    c_msb = 1'b0;
    for (int i = 0; i < GOLDEN_MAX_WIDTH; i++) begin
      if (i < width) begin
        bb       = sub ? ~b[i] : b[i];
        r.sum[i] = a[i] ^ bb ^ c;
        if (i == width - 1) c_msb = c;
        c = (a[i] & bb) | (a[i] & c) | (bb & c);
      end
    end
    r.carry    = c;
    r.overflow = c_msb ^ c;
    return r;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit adder slice: sum, carry out, and the carry that
// entered its own MSB (needed for signed overflow on the top slice).
module chunk_add #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cin_msb
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);
  assign sum  = full[CHUNK-1:0];
  assign cout = full[CHUNK];
  // Recover the carry into the MSB from the MSB sum bit; works for CHUNK==1.
  assign cin_msb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor summing CHUNK bits per clock, LSB chunk first.
// Handshake: a transfer occurs on an edge where valid && ready; valid never depends on ready.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (!cfg_legal(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("chunked_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate

  state_e          state_q, state_d;
  logic            load, step, last;
  logic [WIDTH-1:0] op_a, op_b, sum_q;
  logic            carry_q;
  logic [IDXW-1:0] idx_q;
  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
  logic            chunk_cout, chunk_cin_msb;

  assign last      = (idx_q == LAST_IDX);
  assign chunk_a   = op_a[int'(idx_q)*CHUNK +: CHUNK];
  assign chunk_b   = op_b[int'(idx_q)*CHUNK +: CHUNK];
  assign sum       = sum_q;
  assign dbg_state = state_q;

  chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
    .a       (chunk_a),
    .b       (chunk_b),
    .cin     (carry_q),
    .sum     (chunk_sum),
    .cout    (chunk_cout),
    .cin_msb (chunk_cin_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (load) begin
      // Subtraction is a + ~b + 1: fold the +1 into the initial carry.
      op_a    <= a;
      op_b    <= sub ? ~b : b;
      carry_q <= sub;
      idx_q   <= '0;
    end else if (step) begin
      sum_q[int'(idx_q)*CHUNK +: CHUNK] <= chunk_sum;
      carry_q <= chunk_cout;
      idx_q   <= last ? '0 : idx_q + IDXW'(1);
      if (last) begin
        carry_out <= chunk_cout;
        overflow  <= chunk_cin_msb ^ chunk_cout;
      end
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Directed and golden-model checks of chunked_adder at CHUNK = 8, 32 and 1.
module tb_chunked_adder;
  import adder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_valid = '0;
  logic [2:0]  in_ready, out_valid, carry_out, overflow;
  logic [31:0] a = '0, b = '0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] sum_w [3];
  logic [1:0]  state_w [3];

  int n_tests = 0;
  int n_fail  = 0;
  int nchunk [3] = '{4, 1, 32};

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(32), .CHUNK(8)) dut_c8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid[0]), .out_ready(out_ready),
    .sum(sum_w[0]), .carry_out(carry_out[0]), .overflow(overflow[0]),
    .dbg_state(state_w[0])
  );

  chunked_adder #(.WIDTH(32), .CHUNK(32)) dut_c32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid[1]), .out_ready(out_ready),
    .sum(sum_w[1]), .carry_out(carry_out[1]), .overflow(overflow[1]),
    .dbg_state(state_w[1])
  );

  chunked_adder #(.WIDTH(32), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid[2]), .out_ready(out_ready),
    .sum(sum_w[2]), .carry_out(carry_out[2]), .overflow(overflow[2]),
    .dbg_state(state_w[2])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int d, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv);
    check("ready_idle", in_ready[d], 1'b1);
    a = av;
    b = bv;
    sub = sv;
    in_valid[d] = 1'b1;
    tick();
    in_valid[d] = 1'b0;
    check("ready_busy", in_ready[d], 1'b0);
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 200) begin
      tick();
      lat++;
    end
    if (!out_valid[d]) check("out_valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain(input int d);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ready_after_drain", in_ready[d], 1'b1);
  endtask

  task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, output logic [31:0] s, output logic c,
                        output logic o, output int lat);
    accept(d, av, bv, sv);
    wait_out(d, lat);
    s = sum_w[d];
    c = carry_out[d];
    o = overflow[d];
    drain(d);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic [31:0] s;
    logic        c, o;
  } vec_t;

  initial begin
    vec_t        vecs [6];
    logic [31:0] s;
    logic        c, o;
    int          lat;
    golden_t     g;
    logic [31:0] av, bv;
    logic        sv;

    vecs[0] = '{32'd1,          32'd2,          1'b0, 32'd3,          1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  1'b0, 1'b1};
    vecs[3] = '{32'd5,          32'd10,         1'b1, 32'hFFFF_FFFB,  1'b0, 1'b0};
    vecs[4] = '{32'd10,         32'd5,          1'b1, 32'd5,          1'b1, 1'b0};
    vecs[5] = '{32'h8000_0000,  32'd1,          1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1};

    // Reset
    repeat (2) tick();
    check("rst_in_ready", in_ready[0], 1'b0);
    check("rst_out_valid", out_valid[0], 1'b0);
    check("rst_sum", sum_w[0], 32'd0);
    check("rst_flags", {carry_out[0], overflow[0]}, 2'b00);
    check("rst_state", state_w[0], 2'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready[0], 1'b1);

    // Directed vectors on CHUNK=8
    foreach (vecs[i]) begin
      run_op(0, vecs[i].a, vecs[i].b, vecs[i].sub, s, c, o, lat);
      check("dir_latency", lat, 4);
      check("dir_sum", s, vecs[i].s);
      check("dir_carry", c, vecs[i].c);
      check("dir_overflow", o, vecs[i].o);
    end

    // Backpressure: result held while inputs churn
    accept(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_out(0, lat);
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      b = $urandom;
      sub = 1'($urandom_range(0, 1));
      in_valid[0] = 1'($urandom_range(0, 1));
      tick();
      check("bp_out_valid", out_valid[0], 1'b1);
      check("bp_sum", sum_w[0], 32'h2345_6789);
      check("bp_flags", {carry_out[0], overflow[0]}, 2'b00);
      check("bp_in_ready", in_ready[0], 1'b0);
    end
    in_valid[0] = 1'b0;
    drain(0);
    check("bp_out_valid_after", out_valid[0], 1'b0);

    // Reset mid-BUSY at idx=2
    accept(0, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid[0], 1'b0);
    check("midrst_sum", sum_w[0], 32'd0);
    check("midrst_in_ready", in_ready[0], 1'b1);

    // Reset while a result is pending discards it
    accept(0, 32'd7, 32'd8, 1'b0);
    wait_out(0, lat);
    check("pending_sum", sum_w[0], 32'd15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("donerst_out_valid", out_valid[0], 1'b0);
    check("donerst_sum", sum_w[0], 32'd0);

    // CHUNK=32 and CHUNK=1 against the golden model
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 1000; i++) begin
        av = $urandom;
        bv = $urandom;
        sv = 1'($urandom_range(0, 1));
        if (i % 16 == 0) bv = sv ? av : ~av;
        if (i % 16 == 1) av = 32'h7FFF_FFFF;
        g = golden({32'd0, av}, {32'd0, bv}, sv, 32);
        run_op(d, av, bv, sv, s, c, o, lat);
        check("rnd_latency", lat, nchunk[d]);
        check("rnd_result", {c, o, s}, {g.carry, g.overflow, g.sum[31:0]});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
